// File: rtl/rv_fwd_unit_if.sv
// rv_fwd_unit_if: issue-stage bundle for the operand forwarding / hazard unit.
//
// Handshake: i_issue_valid marks an instruction presented at issue. The
// instruction is accepted (enters the scoreboard) on a rising edge only when
// o_stall=0, i_stall_ext=0 and i_flush=0; while o_stall=1 the issue stage must
// keep presenting the same instruction. o_data/o_fwd_hit/o_stall are valid in
// the same cycle as the source addresses.
interface rv_fwd_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    logic                    i_issue_valid;
    logic                    i_issue_wr;
    logic                    i_issue_late;
    logic [4:0]              i_issue_rd;
    logic [NUM_SRC*5-1:0]    i_rs_addr;
    logic [NUM_SRC-1:0]      i_rs_used;
    logic [NUM_SRC*XLEN-1:0] i_reg_data;
    logic [DEPTH*XLEN-1:0]   i_stage_data;
    logic                    i_stall_ext;
    logic                    i_flush;
    logic [NUM_SRC*XLEN-1:0] o_data;
    logic [NUM_SRC-1:0]      o_fwd_hit;
    logic                    o_stall;
    logic [31:0]             o_stall_cnt;

    // Issue stage side: drives instruction and operand information.
    modport master (
        output i_issue_valid, i_issue_wr, i_issue_late, i_issue_rd,
        output i_rs_addr, i_rs_used, i_reg_data, i_stage_data,
        output i_stall_ext, i_flush,
        input  o_data, o_fwd_hit, o_stall, o_stall_cnt
    );

    // Forwarding unit side.
    modport slave (
        input  i_issue_valid, i_issue_wr, i_issue_late, i_issue_rd,
        input  i_rs_addr, i_rs_used, i_reg_data, i_stage_data,
        input  i_stall_ext, i_flush,
        output o_data, o_fwd_hit, o_stall, o_stall_cnt
    );
endinterface

// File: rtl/rv_fwd_unit.sv
// rv_fwd_unit: operand forwarding and load-use hazard unit for the issue stage.
// Tracks destination registers of DEPTH in-flight instructions in a shift
// register (entry 0 youngest) and selects, per source operand, the youngest
// matching stage result or the register-file value.
// Optional feature macro: RV_FWD_STAT_EN enables the saturating stall-cycle
// counter on o_stall_cnt; without it o_stall_cnt is tied to zero.
module rv_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rv_fwd_unit_if.slave  fwd
);

    // Scoreboard entries: valid, destination register, late-result flag.
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_late;
    logic [4:0]       r_rd [DEPTH];

    logic [NUM_SRC*XLEN-1:0] w_data;
    logic [NUM_SRC-1:0]      w_hit;
    logic [NUM_SRC-1:0]      w_hazard;
    logic                    w_stall;
    logic                    w_new_vld;

    // Per-operand lookup: youngest valid matching entry wins; a late producer
    // that has not yet reached LATE_STAGE is a hazard instead of a forward.
    always_comb begin
        logic [4:0] v_rs;
        logic       v_found;
        w_data   = '0;
        w_hit    = '0;
        w_hazard = '0;
        v_rs     = '0;
        v_found  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            v_rs    = fwd.i_rs_addr[i*5 +: 5];
            v_found = 1'b0;
            // x0 always reads as zero regardless of the register file.
            if (v_rs == 5'd0) begin
                w_data[i*XLEN +: XLEN] = '0;
            end else begin
                w_data[i*XLEN +: XLEN] = fwd.i_reg_data[i*XLEN +: XLEN];
                if (fwd.i_rs_used[i]) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (!v_found && r_vld[k] && (r_rd[k] == v_rs)) begin
                            v_found = 1'b1;
                            if (r_late[k] && (k < LATE_STAGE)) begin
                                w_hazard[i] = 1'b1;
                            end else begin
                                w_data[i*XLEN +: XLEN] = fwd.i_stage_data[k*XLEN +: XLEN];
                                w_hit[i]               = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Stall only matters when an instruction is actually presented.
    assign w_stall = fwd.i_issue_valid & (|w_hazard);

    // New youngest entry: writes to x0, stalled or flushed issues become bubbles.
    assign w_new_vld = fwd.i_issue_valid & fwd.i_issue_wr & (fwd.i_issue_rd != 5'd0)
                     & ~w_stall & ~fwd.i_flush;

    assign fwd.o_data    = w_data;
    assign fwd.o_fwd_hit = w_hit;
    assign fwd.o_stall   = w_stall;

    // Scoreboard update: hold under external freeze (flush still kills entry 0),
    // otherwise shift toward older entries and insert the new issue at entry 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld  <= '0;
            r_late <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (fwd.i_stall_ext) begin
            if (fwd.i_flush) begin
                r_vld[0] <= 1'b0;
            end
        end else begin
            for (int k = DEPTH-1; k > 0; k--) begin
                r_vld[k]  <= r_vld[k-1];
                r_late[k] <= r_late[k-1];
                r_rd[k]   <= r_rd[k-1];
            end
            r_vld[0]  <= w_new_vld;
            r_late[0] <= fwd.i_issue_late;
            r_rd[0]   <= fwd.i_issue_rd;
        end
    end

`ifdef RV_FWD_STAT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where this unit's hazard actually held issue; saturates.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !fwd.i_stall_ext && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fwd.o_stall_cnt = r_stall_cnt;
`else
    assign fwd.o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_fwd_unit.sv
// tb_rv_fwd_unit: directed bench for rv_fwd_unit with an expected-value queue
// and a negedge monitor that pops and compares each presented cycle.
module tb_rv_fwd_unit;

  localparam int XLEN       = 32;
  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 3;
  localparam int LATE_STAGE = 1;
  localparam int W          = 2*XLEN + NUM_SRC + 1 + 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv_fwd_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

  rv_fwd_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LATE_STAGE(LATE_STAGE)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .fwd       (bus)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_cnt = 0;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic late, input logic [4:0] rd,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic ext, input logic flush);
    bus.i_issue_valid = v;
    bus.i_issue_wr    = wr;
    bus.i_issue_late  = late;
    bus.i_issue_rd    = rd;
    bus.i_rs_addr     = {rs1, rs0};
    bus.i_rs_used     = used;
    bus.i_stall_ext   = ext;
    bus.i_flush       = flush;
  endtask

  task automatic set_data(input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    bus.i_reg_data   = {r1, r0};
    bus.i_stage_data = {s2, s1, s0};
  endtask

  // push the expected outputs for the cycle just driven
  task automatic expect_out(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] hit, input logic st, input logic chk_d1);
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [31:0]  c;
`ifdef RV_FWD_STAT_EN
    c = exp_cnt;
`else
    c = 32'd0;
`endif
    e = {d1, d0, hit, st, c};
    m = '1;
    if (!chk_d1) m[W-1 -: 32] = '0;
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
    if (st && !bus.i_stall_ext) exp_cnt++;
  endtask

  // monitor: compare whenever an expectation is pending
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] act;
    string        nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      m   = mask_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.o_data[63:32], bus.o_data[31:0], bus.o_fwd_hit, bus.o_stall, bus.o_stall_cnt};
      n_cmp++;
      if (((act ^ e) & m) != '0) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (care mask %h)", nm, act, e, m);
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // stimulus
  initial begin
    drive(0, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11, 0, 0);
    set_data(32'h11, 32'h22, 32'h0, 32'h0, 32'h0);
    reset_n = 1'b0;

    step(); expect_out("reset_hold", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); reset_n = 1'b1;
    expect_out("post_reset", 32'h11, 32'h22, 2'b00, 0, 1);

    // ALU producer rd=5 forwarded from entries 0, 1, 2, then aged out
    step(); drive(1, 1, 0, 5'd5, 5'd5, 5'd6, 2'b00, 0, 0);
    expect_out("issue_rd5", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); drive(0, 0, 0, 5'd0, 5'd5, 5'd6, 2'b01, 0, 0);
    set_data(32'h11, 32'h22, 32'hAAAA_0001, 32'h0, 32'h0);
    expect_out("fwd_e0", 32'hAAAA_0001, 32'h22, 2'b01, 0, 1);
    step(); set_data(32'h11, 32'h22, 32'h0, 32'hBBBB_0002, 32'h0);
    expect_out("fwd_e1", 32'hBBBB_0002, 32'h22, 2'b01, 0, 1);
    step(); set_data(32'h11, 32'h22, 32'h0, 32'h0, 32'hCCCC_0003);
    expect_out("fwd_e2", 32'hCCCC_0003, 32'h22, 2'b01, 0, 1);
    step(); expect_out("fwd_aged_out", 32'h11, 32'h22, 2'b00, 0, 1);

    // load rd=7 then dependant: one stall cycle, bubble, then forward from entry 1
    step(); drive(1, 1, 1, 5'd7, 5'd5, 5'd6, 2'b00, 0, 0);
    expect_out("issue_load", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); drive(1, 1, 0, 5'd8, 5'd8, 5'd7, 2'b11, 0, 0);
    set_data(32'h11, 32'h22, 32'h0, 32'hDDDD_0007, 32'h0);
    expect_out("load_use_stall", 32'h11, 32'h0, 2'b00, 1, 0);
    step(); expect_out("load_use_fwd", 32'h11, 32'hDDDD_0007, 2'b10, 0, 1);

    // dependant rd=8 now entry 0; then back-to-back rd=3 writes
    step(); drive(1, 1, 0, 5'd3, 5'd8, 5'd6, 2'b01, 0, 0);
    set_data(32'h11, 32'h22, 32'h8888_0008, 32'h0, 32'h0);
    expect_out("dep_fwd_e0", 32'h8888_0008, 32'h22, 2'b01, 0, 1);
    step(); drive(1, 1, 0, 5'd3, 5'd8, 5'd6, 2'b00, 0, 0);
    expect_out("issue_rd3_again", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); drive(1, 1, 0, 5'd0, 5'd3, 5'd0, 2'b11, 0, 0);
    set_data(32'h11, 32'h22, 32'h2, 32'h1, 32'h0);
    expect_out("youngest_wins", 32'h2, 32'h0, 2'b01, 0, 1);
    step(); drive(0, 0, 0, 5'd0, 5'd0, 5'd3, 2'b11, 0, 0);
    set_data(32'h11, 32'h22, 32'h0, 32'h1111_0013, 32'h0);
    expect_out("rd0_not_tracked", 32'h0, 32'h1111_0013, 2'b10, 0, 1);

    // external freeze holds rd=9 in entry 0 for 3 cycles
    step(); drive(1, 1, 0, 5'd9, 5'd5, 5'd6, 2'b00, 0, 0);
    expect_out("issue_rd9", 32'h11, 32'h22, 2'b00, 0, 1);
    set_data(32'h11, 32'h22, 32'h9999_0009, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); drive(1, 1, 0, 5'd10, 5'd9, 5'd6, 2'b01, 1, 0);
      expect_out("ext_hold", 32'h9999_0009, 32'h22, 2'b01, 0, 1);
    end
    step(); drive(0, 0, 0, 5'd0, 5'd9, 5'd10, 2'b11, 0, 0);
    expect_out("ext_release", 32'h9999_0009, 32'h22, 2'b01, 0, 1);
    step(); set_data(32'h11, 32'h22, 32'h0, 32'h9999_1009, 32'h0);
    expect_out("after_ext_e1", 32'h9999_1009, 32'h22, 2'b01, 0, 1);
    step(); set_data(32'h11, 32'h22, 32'h0, 32'h0, 32'h9999_2009);
    expect_out("after_ext_e2", 32'h9999_2009, 32'h22, 2'b01, 0, 1);

    // flush kills the issued rd=4; an unflushed rd=4 forwards
    step(); drive(1, 1, 0, 5'd4, 5'd5, 5'd6, 2'b00, 0, 1);
    expect_out("flush_issue", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); drive(1, 1, 0, 5'd4, 5'd4, 5'd6, 2'b01, 0, 0);
    expect_out("flushed_no_hit", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); drive(0, 0, 0, 5'd0, 5'd4, 5'd6, 2'b01, 0, 0);
    set_data(32'h11, 32'h22, 32'h4444_0004, 32'h0, 32'h0);
    expect_out("rd4_fwd", 32'h4444_0004, 32'h22, 2'b01, 0, 1);

    // asynchronous reset mid-stream
    step(); reset_n = 1'b0; exp_cnt = 0;
    expect_out("async_reset", 32'h11, 32'h22, 2'b00, 0, 1);
    step(); reset_n = 1'b1;
    expect_out("post_reset_clear", 32'h11, 32'h22, 2'b00, 0, 1);

    // final report
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_fwd_unit.md
# rv_fwd_unit

Parametrised operand forwarding and hazard unit for the issue stage. It tracks the destination registers of up to DEPTH in-flight instructions in a shift-register scoreboard and selects, per source operand, the youngest matching stage result or the register-file value. It raises a load-use stall when the matching producer's result is not yet available. It replaces the fixed two-operand, three-source bypass mux and sits between register read and the ALU operand latches.

## Interface
- XLEN, 32, datapath width
- NUM_SRC, 2, number of source operands (1..3)
- DEPTH, 3, tracked pipeline stages after issue (2..6); entry 0 is youngest
- LATE_STAGE, 1, first entry index at which a late (load) result is valid (0..DEPTH-1)

- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  instruction presented at issue this cycle
- i_issue_wr  in  1  instruction writes a register
- i_issue_late  in  1  result produced late (load class)
- i_issue_rd  in  5  destination register
- i_rs_addr  in  NUM_SRC*5  source register addresses, operand i at [i*5 +: 5]
- i_rs_used  in  NUM_SRC  operand i actually read
- i_reg_data  in  NUM_SRC*XLEN  register-file read data
- i_stage_data  in  DEPTH*XLEN  result data of each tracked entry, entry k at [k*XLEN +: XLEN]
- i_stall_ext  in  1  external pipeline freeze
- i_flush  in  1  kill the instruction at issue and entry 0
- o_data  out  NUM_SRC*XLEN  forwarded operands
- o_fwd_hit  out  NUM_SRC  operand i taken from a stage, not the register file
- o_stall  out  1  hazard stall request to issue
- o_stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Entry fields: valid, rd[4:0], late. Reset: all valid=0, so o_stall=0, o_fwd_hit=0, o_data=i_reg_data (x0 gives 0), o_stall_cnt=0.
- Operand i lookup:
  - If !i_rs_used[i] or rs=0, the operand is i_reg_data for rs≠0 and 0 for rs=0, with no hit and no hazard.
  - Otherwise scan entries 0→DEPTH-1. The first valid entry with rd==rs wins (youngest priority).
  - Winner k with late=1 and k<LATE_STAGE is a hazard for operand i.
  - Any other winner gives o_data[i]=i_stage_data[k] and o_fwd_hit[i]=1.
  - No winner gives i_reg_data[i].
- o_stall = i_issue_valid & OR of operand hazards. It is independent of i_stall_ext.
- Update at rising edge:
  - i_stall_ext=1: hold all entries. Highest priority, except that i_flush still clears entry 0.
  - Else shift e[k+1]<=e[k] and drop e[DEPTH-1].
  - e[0] <= {i_issue_valid & i_issue_wr & rd≠0 & !o_stall & !i_flush, i_issue_rd, i_issue_late}.
  - o_stall inserts a bubble (entry 0 invalid) while older entries advance.
  - i_flush invalidates the new entry 0. Entries 1..DEPTH-1 shift normally.
- Same rd in multiple entries is legal; the youngest entry wins.

## Timing
- o_data, o_fwd_hit and o_stall are combinational from inputs and registered entries, available in the same cycle. No added latency.
- Scoreboard update latency is 1 cycle: an instruction issued in cycle N is entry 0 in cycle N+1 and entry k in cycle N+1+k (absent i_stall_ext).
- Load-use with LATE_STAGE=1: a dependant in cycle N+1 stalls exactly 1 cycle, then forwards from entry 1 in N+2.
- Asynchronous reset mid-operation clears all entries immediately. Outputs revert to register-file pass-through in the same cycle.

## Configuration
- RV_FWD_STAT_EN defined: o_stall_cnt increments by 1 on each rising edge with o_stall=1 and i_stall_ext=0. It saturates at 0xFFFF_FFFF and is cleared by reset.
- Not defined: no counter register; o_stall_cnt is tied to 0.

## Test plan
- Reset, then rs1=5, rs2=6, reg data 0x11/0x22, no entries -> o_data = 0x11/0x22, o_fwd_hit=00, o_stall=0.
- Issue ALU op rd=5; next cycle rs1=5, i_stage_data[0]=0xAAAA_0001 -> o_data[0]=0xAAAA_0001, o_fwd_hit[0]=1. Two cycles later the same operand comes from i_stage_data[2].
- Issue load rd=7 (late); next cycle rs2=7 -> o_stall=1 for exactly 1 cycle and entry 0 becomes a bubble. The following cycle o_data[1]=i_stage_data[1], o_stall=0. With RV_FWD_STAT_EN, o_stall_cnt=1.
- Back-to-back writes to rd=3 with entry0 data 0x2 and entry1 data 0x1, then read rs1=3 -> 0x2 (youngest wins). Read rs1=0 with an entry rd=0 attempted -> 0, no hit.
- i_stall_ext=1 for 3 cycles with rd=9 in entry 0 -> the entry stays at index 0 and forwarding still hits entry 0. After release it advances one entry per cycle.
- i_flush with issue rd=4 -> next cycle rs1=4 reads i_reg_data with no hit. An assertion of i_reset_n=0 mid-stream -> o_fwd_hit=0 and o_stall=0 immediately.
